// File: rtl/cache_2way.sv
// cache_2way: 2-way set-associative write-back/write-allocate cache with a private 32-word backing memory.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_2way (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic       write,
  input  logic [2:0] tag,
  input  logic [1:0] index,
  input  logic [2:0] data_in,
  output logic       hit,
  output logic       miss,
  output logic [2:0] data_out,
  output logic       dirty,
  output logic       valid,
  output logic [1:0] lru,
  output logic       writeBack,
  output logic       way,
  output logic [2:0] tag_before
`ifdef CACHE_STATS_EN
  ,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
`endif
);
  logic [1:0] vld [4];
  logic [1:0] drt [4];
  logic [2:0] tags [4][2];
  logic [2:0] data [4][2];
  logic       lru_ptr [4];
  logic [2:0] mem [32];
  logic       h0, h1, is_hit, sel, wb, new_dirty;
  logic [2:0] fill, new_data;
  assign h0 = vld[index][0] && tags[index][0] == tag;
  assign h1 = vld[index][1] && tags[index][1] == tag;
  assign is_hit = h0 | h1;
  // Victim preference: invalid way0, then invalid way1, then the LRU way.
  assign sel = h0 ? 1'b0 : h1 ? 1'b1 : !vld[index][0] ? 1'b0 : !vld[index][1] ? 1'b1 : lru_ptr[index];
  assign wb = !is_hit && vld[index][sel] && drt[index][sel];
  assign fill = mem[{tag, index}];
  assign new_data = write ? data_in : is_hit ? data[index][sel] : fill;
  assign new_dirty = write | (is_hit & drt[index][sel]);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        vld[s] <= '0;
        drt[s] <= '0;
        lru_ptr[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          tags[s][w] <= '0;
          data[s][w] <= '0;
        end
      end
      for (int a = 0; a < 32; a++) mem[a] <= 3'(a >> 2);
      hit <= 1'b0;
      miss <= 1'b0;
      data_out <= '0;
      dirty <= 1'b0;
      valid <= 1'b0;
      lru <= '0;
      writeBack <= 1'b0;
      way <= 1'b0;
      tag_before <= '0;
`ifdef CACHE_STATS_EN
      hit_count <= '0;
      miss_count <= '0;
`endif
    end else if (read || write) begin
      // Write-back uses the pre-access victim contents; fill reads a different address.
      if (wb) mem[{tags[index][sel], index}] <= data[index][sel];
      vld[index][sel] <= 1'b1;
      drt[index][sel] <= new_dirty;
      tags[index][sel] <= tag;
      data[index][sel] <= new_data;
      lru_ptr[index] <= ~sel;
      hit <= is_hit;
      miss <= !is_hit;
      data_out <= new_data;
      dirty <= new_dirty;
      valid <= 1'b1;
      lru <= sel ? 2'b01 : 2'b10;
      writeBack <= wb;
      way <= sel;
      tag_before <= vld[index][sel] ? tags[index][sel] : 3'd0;
`ifdef CACHE_STATS_EN
      if (is_hit && hit_count != 8'hff) hit_count <= hit_count + 8'd1;
      if (!is_hit && miss_count != 8'hff) miss_count <= miss_count + 8'd1;
`endif
    end else begin
      hit <= 1'b0;
      miss <= 1'b0;
      writeBack <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_2way.sv
// tb_cache_2way: directed scoreboard bench for cache_2way.
module tb_cache_2way;
  logic       clk = 1'b0;
  logic       rst, read, write;
  logic [2:0] tag, data_in;
  logic [1:0] index;
  logic       hit, miss, dirty, valid, writeBack, way;
  logic [2:0] data_out, tag_before;
  logic [1:0] lru;
`ifdef CACHE_STATS_EN
  logic [7:0] hit_count, miss_count;
`endif
  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [2:0] d;
    logic       dirty;
    logic       valid;
    logic [1:0] lru;
    logic       wb;
    logic       way;
    logic [2:0] tb;
  } exp_t;
  exp_t  exp_q [$];
  string name_q [$];
  int    vectors = 0;
  int    errors = 0;
  cache_2way dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .tag(tag), .index(index),
    .data_in(data_in), .hit(hit), .miss(miss), .data_out(data_out), .dirty(dirty),
    .valid(valid), .lru(lru), .writeBack(writeBack), .way(way), .tag_before(tag_before)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_t  e, g;
    string n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = '{hit, miss, data_out, dirty, valid, lru, writeBack, way, tag_before};
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got hit=%b miss=%b d=%0d dirty=%b valid=%b lru=%b wb=%b way=%b tb=%0d, want hit=%b miss=%b d=%0d dirty=%b valid=%b lru=%b wb=%b way=%b tb=%0d",
          n, g.hit, g.miss, g.d, g.dirty, g.valid, g.lru, g.wb, g.way, g.tb,
          e.hit, e.miss, e.d, e.dirty, e.valid, e.lru, e.wb, e.way, e.tb);
      end
    end
  end
  task automatic apply(input logic r, input logic w, input logic rs, input logic [2:0] t,
                       input logic [1:0] i, input logic [2:0] d, input exp_t e, input string n);
    @(negedge clk);
    rst = rs; read = r; write = w; tag = t; index = i; data_in = d;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; tag = '0; index = '0; data_in = '0;
    //                    r  w  rst t  i  d      hit miss d  dirty vld lru    wb way tb
    apply(0, 0, 1, 0, 0, 0, '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0}, "reset");
    apply(1, 0, 0, 4, 0, 0, '{0, 1, 4, 0, 1, 2'b10, 0, 0, 0}, "rd_t4_i0_miss");
    apply(1, 0, 0, 5, 0, 0, '{0, 1, 5, 0, 1, 2'b01, 0, 1, 0}, "rd_t5_i0_miss_way1");
    apply(1, 0, 0, 4, 0, 0, '{1, 0, 4, 0, 1, 2'b10, 0, 0, 4}, "rd_t4_i0_hit");
    apply(0, 1, 0, 0, 1, 7, '{0, 1, 7, 1, 1, 2'b10, 0, 0, 0}, "wr_t0_i1_alloc");
    apply(0, 1, 0, 7, 2, 2, '{0, 1, 2, 1, 1, 2'b10, 0, 0, 0}, "wr_t7_i2");
    apply(0, 1, 0, 6, 2, 3, '{0, 1, 3, 1, 1, 2'b01, 0, 1, 0}, "wr_t6_i2");
    apply(1, 0, 0, 1, 2, 0, '{0, 1, 1, 0, 1, 2'b10, 1, 0, 7}, "rd_t1_i2_evict_dirty");
    apply(1, 0, 0, 7, 2, 0, '{0, 1, 2, 0, 1, 2'b01, 1, 1, 6}, "rd_t7_i2_refetch_wb");
    apply(1, 1, 0, 4, 0, 6, '{1, 0, 6, 1, 1, 2'b10, 0, 0, 4}, "rw_priority_write");
    apply(0, 0, 0, 4, 0, 0, '{0, 0, 6, 1, 1, 2'b10, 0, 0, 4}, "idle_hold");
    apply(1, 0, 0, 0, 1, 0, '{1, 0, 7, 1, 1, 2'b10, 0, 0, 0}, "rd_t0_i1_hit_dirty");
    apply(1, 0, 0, 0, 3, 0, '{0, 1, 0, 0, 1, 2'b10, 0, 0, 0}, "rd_t0_invalid_no_hit");
    apply(1, 0, 1, 7, 2, 0, '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0}, "mid_reset");
    apply(1, 0, 0, 7, 2, 0, '{0, 1, 7, 0, 1, 2'b10, 0, 0, 0}, "rd_t7_i2_mem_reinit");
    apply(0, 0, 0, 0, 0, 0, '{0, 0, 7, 0, 1, 2'b10, 0, 0, 0}, "idle_after_reset");
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
